// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : seq_pkg
//  Brief   : Shared opcode, ALU-control and state encodings for the
//            datapath sequencer, plus instruction field positions.
//  Revision: 1.0  initial release
// ============================================================================
package seq_pkg;

    // Controller states; binary encoded, one instruction in flight at a time
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LDA  = 3'd1,
        S_LDB  = 3'd2,
        S_EXE  = 3'd3,
        S_WB   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam int INSTR_W   = 16;
    localparam int RADDR_W   = 3;

    // Instruction fields: {op[15:13], rd[12:10], rn[9:7], rm[6:4], sh[3:2], 2'b00}
    localparam int OP_LSB    = 13;
    localparam int RD_LSB    = 10;
    localparam int RN_LSB    = 7;
    localparam int RM_LSB    = 4;
    localparam int SH_LSB    = 2;

    localparam logic [2:0] OP_MOVI = 3'b000;
    localparam logic [2:0] OP_MOV  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_CMP  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_MVN  = 3'b101;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    // Opcodes 110 and 111 have no datapath meaning
    function automatic logic is_illegal(input logic [2:0] op);
        return (op == 3'b110) || (op == 3'b111);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vDFF.sv
`default_nettype none
// ============================================================================
//  Module  : vDFF
//  Brief   : Plain N-bit rising-edge register; any load or reset behaviour
//            is built as a mux in front of d_i by the user.
//  Revision: 1.0  initial release
// ============================================================================
module vDFF #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    // Capture d_i every rising edge
    always_ff @(posedge clk) begin
        q_o <= d_i;
    end

endmodule
`default_nettype wire

// File: rtl/datapath_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : datapath_sequencer
//  Brief   : Moore controller that steps the lab5 datapath through one
//            16-bit instruction: operand loads, execute, writeback, done.
//            start/busy/done handshake, one instruction in flight.
//  Revision: 1.0  initial release
// ============================================================================
module datapath_sequencer
    import seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [INSTR_W-1:0]  instr,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [RADDR_W-1:0]  readnum,
    output logic [RADDR_W-1:0]  writenum,
    output logic                write,
    output logic                vsel,
    output logic                loada,
    output logic                loadb,
    output logic                asel,
    output logic                bsel,
    output logic [1:0]          shift,
    output logic [1:0]          ALUop,
    output logic                loadc,
    output logic                loads
);

    logic [INSTR_W-1:0] instr_d;
    logic [INSTR_W-1:0] instr_q;
    state_t             state_d;
    state_t             state_q;
    logic [2:0]         state_q_bits;

    // Latched fields; all control decode uses these, never the live instr
    logic [2:0]         op_q;
    logic [2:0]         rd_q;
    logic [2:0]         rn_q;
    logic [2:0]         rm_q;
    logic [1:0]         sh_q;
    logic [2:0]         op_in;
    logic               unused_instr_lsbs;

    assign op_q  = instr_q[OP_LSB +: 3];
    assign rd_q  = instr_q[RD_LSB +: 3];
    assign rn_q  = instr_q[RN_LSB +: 3];
    assign rm_q  = instr_q[RM_LSB +: 3];
    assign sh_q  = instr_q[SH_LSB +: 2];
    assign op_in = instr[OP_LSB +: 3];

    // The two low instruction bits are always zero and carry no control
    assign unused_instr_lsbs = ^instr_q[1:0];

    vDFF #(.N(INSTR_W)) u_instr_reg (
        .clk (clk),
        .d_i (instr_d),
        .q_o (instr_q)
    );

    vDFF #(.N(3)) u_state_reg (
        .clk (clk),
        .d_i (state_d),
        .q_o (state_q_bits)
    );

    assign state_q = state_t'(state_q_bits);

    // Next state and instruction latch; reset overrides everything, including start
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    instr_d = instr;
                    if (is_illegal(op_in)) begin
                        state_d = S_DONE;
                    end else if (op_in == OP_MOVI) begin
                        state_d = S_WB;
                    end else if ((op_in == OP_MOV) || (op_in == OP_MVN)) begin
                        state_d = S_LDB;
                    end else begin
                        state_d = S_LDA;
                    end
                end
            end
            S_LDA:   state_d = S_LDB;
            S_LDB:   state_d = S_EXE;
            S_EXE:   state_d = (op_q == OP_CMP) ? S_DONE : S_WB;
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (!rst_n) begin
            state_d = S_IDLE;
            instr_d = '0;
        end
    end

    // Moore output decode from the current state and latched instruction
    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = 1'b0;
        err      = 1'b0;
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        vsel     = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = ALU_ADD;
        loadc    = 1'b0;
        loads    = 1'b0;
        case (state_q)
            S_LDA: begin
                readnum = rn_q;
                loada   = 1'b1;
            end
            S_LDB: begin
                readnum = rm_q;
                loadb   = 1'b1;
            end
            S_EXE: begin
                shift = sh_q;
                // Single-operand ops zero the A side so the ALU passes sh(Rm)
                asel  = (op_q == OP_MOV) || (op_q == OP_MVN);
                loadc = 1'b1;
                loads = (op_q == OP_CMP);
                case (op_q)
                    OP_CMP:  ALUop = ALU_SUB;
                    OP_AND:  ALUop = ALU_AND;
                    OP_MVN:  ALUop = ALU_NOTB;
                    default: ALUop = ALU_ADD;
                endcase
            end
            S_WB: begin
                writenum = rd_q;
                write    = 1'b1;
                vsel     = (op_q == OP_MOVI);
            end
            S_DONE: begin
                done = 1'b1;
                err  = is_illegal(op_q);
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_datapath_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_datapath_sequencer
//  Brief   : Sequencer driving a behavioural lab5 datapath; a scoreboard of
//            expected register file / Z / handshake timing is filled at issue
//            and drained by a monitor at every done pulse.
//  Revision: 1.0  initial release
// ============================================================================
module tb_datapath_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] instr = 16'h0;
    logic        busy, done, err, write, vsel, loada, loadb, asel, bsel, loadc, loads;
    logic [2:0]  readnum, writenum;
    logic [1:0]  shift, ALUop;

    datapath_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .instr    (instr),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .vsel     (vsel),
        .loada    (loada),
        .loadb    (loadb),
        .asel     (asel),
        .bsel     (bsel),
        .shift    (shift),
        .ALUop    (ALUop),
        .loadc    (loadc),
        .loads    (loads)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural datapath driven by the DUT ----------------
    logic [15:0] dp_regs [0:7] = '{default: 16'h0};
    logic [15:0] dp_a = 16'h0, dp_b = 16'h0, dp_c = 16'h0, din = 16'h0;
    logic        dp_z = 1'b0;
    logic [15:0] dp_bsh, dp_ain, dp_bin, dp_alu;
    logic [7:0][15:0] dp_pk;

    always_comb begin
        case (shift)
            2'b00:   dp_bsh = dp_b;
            2'b01:   dp_bsh = {dp_b[14:0], 1'b0};
            2'b10:   dp_bsh = {1'b0, dp_b[15:1]};
            default: dp_bsh = {dp_b[15], dp_b[15:1]};
        endcase
        dp_ain = asel ? 16'h0 : dp_a;
        dp_bin = bsel ? {11'b0, din[4:0]} : dp_bsh;
        case (ALUop)
            2'b00:   dp_alu = dp_ain + dp_bin;
            2'b01:   dp_alu = dp_ain - dp_bin;
            2'b10:   dp_alu = dp_ain & dp_bin;
            default: dp_alu = ~dp_bin;
        endcase
        for (int i = 0; i < 8; i++) dp_pk[i] = dp_regs[i];
    end

    always @(posedge clk) begin
        if (write) dp_regs[writenum] <= vsel ? din : dp_c;
        if (loada) dp_a <= dp_regs[readnum];
        if (loadb) dp_b <= dp_regs[readnum];
        if (loadc) dp_c <= dp_alu;
        if (loads) dp_z <= (dp_alu == 16'h0);
    end

    // ---------------- reference model and scoreboard ----------------
    logic [15:0] ref_regs [0:7] = '{default: 16'h0};
    logic        ref_z = 1'b0;

    typedef struct packed {
        int unsigned      issue_cyc;
        int unsigned      lat;
        logic             err;
        int unsigned      nwrite;
        int unsigned      nload;
        logic [7:0][15:0] regs;
        logic             z;
    } exp_t;

    exp_t sb_q[$];

    function automatic logic [15:0] ref_shift(input logic [15:0] v, input logic [1:0] s);
        int unsigned x;
        x = v;
        case (s)
            2'd0:    return v;
            2'd1:    return 16'((x * 2) % 65536);
            2'd2:    return 16'(x / 2);
            default: return 16'(x / 2) | (v & 16'h8000);
        endcase
    endfunction

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rn, input logic [2:0] rm,
                                       input logic [1:0] sh);
        return {op, rd, rn, rm, sh, 2'b00};
    endfunction

    // Wait at negedges until idle; pokes start with junk while busy (must be ignored)
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 80) begin
            start = 1'($urandom_range(0, 1));
            instr = 16'($urandom);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (n >= 80) check("idle_wait_timeout", busy, 1'b0);
    endtask

    task automatic issue(input logic [15:0] ins, input logic [15:0] d);
        exp_t        e;
        logic [2:0]  op, rd, rn, rm;
        logic [1:0]  sh;
        logic [15:0] b, a;
        wait_idle();
        op = ins[15:13]; rd = ins[12:10]; rn = ins[9:7]; rm = ins[6:4]; sh = ins[3:2];
        b = ref_shift(ref_regs[rm], sh);
        a = ref_regs[rn];
        e.err = 1'b0; e.nwrite = 1;
        case (op)
            3'd0: begin e.lat = 2; e.nload = 0; ref_regs[rd] = d;      end
            3'd1: begin e.lat = 4; e.nload = 2; ref_regs[rd] = b;      end
            3'd2: begin e.lat = 5; e.nload = 3; ref_regs[rd] = a + b;  end
            3'd3: begin e.lat = 4; e.nload = 4; e.nwrite = 0; ref_z = (a == b); end
            3'd4: begin e.lat = 5; e.nload = 3; ref_regs[rd] = a & b;  end
            3'd5: begin e.lat = 4; e.nload = 2; ref_regs[rd] = ~b;     end
            default: begin e.lat = 1; e.nload = 0; e.nwrite = 0; e.err = 1'b1; end
        endcase
        for (int i = 0; i < 8; i++) e.regs[i] = ref_regs[i];
        e.z = ref_z;
        e.issue_cyc = cyc;
        sb_q.push_back(e);
        start = 1'b1;
        instr = ins;
        din   = d;
        @(negedge clk);
        start = 1'b0;
        instr = 16'($urandom);
    endtask

    function automatic logic [7:0][15:0] ref_pk();
        logic [7:0][15:0] r;
        for (int i = 0; i < 8; i++) r[i] = ref_regs[i];
        return r;
    endfunction

    // ---------------- monitor ----------------
    int unsigned mon_w = 0, mon_l = 0, quiet_viol = 0, busy_viol = 0;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (!busy) begin
            if ({done, err, readnum, writenum, write, vsel, loada, loadb, asel,
                 shift, ALUop, loadc, loads} != '0) quiet_viol++;
            mon_w = 0;
            mon_l = 0;
        end
        if (bsel) quiet_viol++;
        if (err && !done) quiet_viol++;
        if (sb_q.size() != 0 && cyc > sb_q[0].issue_cyc && !busy) busy_viol++;
        mon_w += int'(write);
        mon_l += int'(loada) + int'(loadb) + int'(loadc) + int'(loads);
        if (done) begin
            check("done_has_txn", sb_q.size() != 0, 1'b1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check("latency", cyc - mon_e.issue_cyc, mon_e.lat);
                check("err", err, mon_e.err);
                check("write_pulses", mon_w, mon_e.nwrite);
                check("load_pulses", mon_l, mon_e.nload);
                check("regfile", dp_pk, mon_e.regs);
                check("z_flag", dp_z, mon_e.z);
            end
            mon_w = 0;
            mon_l = 0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        instr = mk(3'd2, 3'd1, 3'd1, 3'd1, 2'd0);
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {busy, done, err, readnum, writenum, write, vsel, loada, loadb,
               asel, bsel, shift, ALUop, loadc, loads}, '0);
        rst_n = 1'b1;
        start = 1'b0;

        issue(mk(3'd0, 3'd0, 3'd0, 3'd0, 2'd0), 16'h0007);   // MOVI R0 = 7
        issue(mk(3'd0, 3'd1, 3'd0, 3'd0, 2'd0), 16'h0002);   // MOVI R1 = 2
        issue(mk(3'd2, 3'd2, 3'd1, 3'd0, 2'd1), 16'h0000);   // ADD R2 = R1 + (R0<<1)
        issue(mk(3'd3, 3'd0, 3'd0, 3'd0, 2'd0), 16'h0000);   // CMP R0, R0
        issue(mk(3'd5, 3'd3, 3'd0, 3'd1, 2'd0), 16'h0000);   // MVN R3 = ~R1
        issue(mk(3'd7, 3'd0, 3'd0, 3'd0, 2'd0), 16'h0000);   // illegal

        // Reset while an ADD sits in execute: aborts with no writeback
        wait_idle();
        start = 1'b1;
        instr = mk(3'd2, 3'd4, 3'd2, 3'd3, 2'd0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("exe_before_reset", {busy, write, loadc}, 3'b101);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_outputs", {busy, write, done}, 3'b000);
        check("abort_regfile", dp_pk, ref_pk());
        check("abort_z", dp_z, ref_z);

        repeat (60) begin
            issue(mk(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom),
                     3'($urandom), 2'($urandom)), 16'($urandom));
        end

        wait_idle();
        repeat (5) @(negedge clk);
        check("idle_quiet", quiet_viol, 0);
        check("busy_held", busy_viol, 0);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
